basepair_packer: RTL and testbench

// - Front-end producer for the seed-index/aligner stage: consumes a byte stream of ASCII nucleotides
//   and packs it into the 2-bit-per-base reference and short-read words the aligner loads on reset.
// - One frame = REF_BASES reference bases then READ_BASES short-read bases; the frame is held stable

---
 rtl/basepair_packer_if.sv | 26 ++
 rtl/basepair_packer.sv | 120 ++++++++++++
 tb/tb_basepair_packer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/basepair_packer_if.sv
// Byte-in / frame-out bundle between the nucleotide source, the packer and the aligner loader.
// master = source/consumer side, slave = basepair_packer.
interface basepair_packer_if #(
  parameter int REF_BASES  = 50,
  parameter int READ_BASES = 8
);
  logic [7:0]              base_char;
  logic                    base_valid;
  logic                    base_ready;
  logic [2*REF_BASES-1:0]  reference;
  logic [2*READ_BASES-1:0] shortread;
  logic                    frame_valid;
  logic                    frame_ack;
  logic                    bad_char;
  logic [7:0]              err_count;

  modport master (
    output base_char, base_valid, frame_ack,
    input  base_ready, reference, shortread, frame_valid, bad_char, err_count
  );

  modport slave (
    input  base_char, base_valid, frame_ack,
    output base_ready, reference, shortread, frame_valid, bad_char, err_count
  );
endinterface

// File: rtl/basepair_packer.sv
// Packs ASCII nucleotides into 2-bit reference / short-read words, one frame held until acked.
// Optional macro LOWERCASE_BASES_EN: also accept 'a','g','c','t' with the uppercase codes.
//
// state  | meaning
// S_REF  | filling reference word, ptr = next reference base
// S_READ | filling short-read word, ptr = next short-read base
// S_HOLD | frame complete and frozen, waiting for frame_ack
module basepair_packer #(
  parameter int REF_BASES  = 50,
  parameter int READ_BASES = 8
) (
  input logic          clk,
  input logic          reset,
  basepair_packer_if.slave bp
);
  localparam int MAX_BASES = (REF_BASES > READ_BASES) ? REF_BASES : READ_BASES;
  localparam int PTR_W     = (MAX_BASES > 1) ? $clog2(MAX_BASES) : 1;

  typedef enum logic [1:0] {S_REF, S_READ, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [2*REF_BASES-1:0]  ref_q, ref_d;
  logic [2*READ_BASES-1:0] read_q, read_d;
  logic                    fv_q, fv_d;
  logic                    bad_q, bad_d;
  logic [7:0]              err_q, err_d;

  logic       xfer;
  logic       legal;
  logic [1:0] code;

  always_comb begin
    legal = 1'b1;
    code  = 2'b00;
    case (bp.base_char)
      8'h41: code = 2'b00;
      8'h47: code = 2'b01;
      8'h43: code = 2'b10;
      8'h54: code = 2'b11;
`ifdef LOWERCASE_BASES_EN
      8'h61: code = 2'b00;
      8'h67: code = 2'b01;
      8'h63: code = 2'b10;
      8'h74: code = 2'b11;
`else
`endif
      default: legal = 1'b0;
    endcase
  end

  assign bp.base_ready = (state_q != S_HOLD) & ~reset;
  assign xfer          = bp.base_valid & bp.base_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ref_d   = ref_q;
    read_d  = read_q;
    case (state_q)
      S_REF: begin
        if (xfer && legal) begin
          ref_d[{ptr_q, 1'b0} +: 2] = code;
          if (ptr_q == PTR_W'(REF_BASES - 1)) begin
            state_d = S_READ;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (xfer && legal) begin
          read_d[{ptr_q, 1'b0} +: 2] = code;
          if (ptr_q == PTR_W'(READ_BASES - 1)) begin
            state_d = S_HOLD;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bp.frame_ack) state_d = S_REF;
      end
      default: state_d = S_REF;
    endcase

    fv_d  = (state_d == S_HOLD);
    bad_d = xfer & ~legal;
    // illegal bytes still complete the handshake; only the error counter moves
    err_d = (xfer && !legal && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REF;
      ptr_q   <= '0;
      ref_q   <= '0;
      read_q  <= '0;
      fv_q    <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ref_q   <= ref_d;
      read_q  <= read_d;
      fv_q    <= fv_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  assign bp.reference   = ref_q;
  assign bp.shortread   = read_q;
  assign bp.frame_valid = fv_q;
  assign bp.bad_char    = bad_q;
  assign bp.err_count   = err_q;
endmodule

// File: tb/tb_basepair_packer.sv
// Scoreboard bench for basepair_packer: driver feeds bytes and a base-list model,
// a negedge monitor compares bad_char per transfer and each completed frame.
module tb_basepair_packer;
  localparam int NREF  = 50;
  localparam int NREAD = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  basepair_packer_if #(.REF_BASES(NREF), .READ_BASES(NREAD)) bp ();

  basepair_packer #(.REF_BASES(NREF), .READ_BASES(NREAD)) dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bp)
  );

  typedef struct {
    logic [2*NREF-1:0]  r;
    logic [2*NREAD-1:0] s;
    logic [7:0]         e;
  } frame_t;

  frame_t exp_q[$];
  bit     bad_exp_q[$];

  logic [2*NREF-1:0]  m_ref;
  logic [2*NREAD-1:0] m_read;
  int                 m_pos;
  int                 m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  // -1 = not a nucleotide
  function automatic int code_of(input logic [7:0] c);
    case (c)
      "A": return 0;
      "G": return 1;
      "C": return 2;
      "T": return 3;
`ifdef LOWERCASE_BASES_EN
      "a": return 0;
      "g": return 1;
      "c": return 2;
      "t": return 3;
`endif
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    bad_exp_q.delete();
    m_ref  = '0;
    m_read = '0;
    m_pos  = 0;
    m_err  = 0;
  endtask

  task automatic model_accept(input logic [7:0] c);
    int code;
    frame_t f;
    code = code_of(c);
    bad_exp_q.push_back(code < 0);
    if (code < 0) begin
      if (m_err < 255) m_err++;
    end else begin
      if (m_pos < NREF) m_ref[2*m_pos +: 2] = 2'(code);
      else              m_read[2*(m_pos-NREF) +: 2] = 2'(code);
      m_pos++;
      if (m_pos == NREF + NREAD) begin
        f.r = m_ref; f.s = m_read; f.e = 8'(m_err);
        exp_q.push_back(f);
        m_pos = 0;
      end
    end
  endtask

  // called at posedge+1; leaves base_valid high so bytes go back-to-back
  task automatic send(input logic [7:0] c);
    bit acc;
    acc = 1'b0;
    bp.base_char  = c;
    bp.base_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = bp.base_ready;
      @(posedge clk); #1;
    end
    if (acc) model_accept(c);
    else check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bp.base_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ack();
    bp.base_valid = 1'b0;
    bp.frame_ack  = 1'b1;
    @(posedge clk); #1;
    bp.frame_ack  = 1'b0;
    check("ack_fv_low", bp.frame_valid, 0);
    check("ack_ready", bp.base_ready, 1);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] tbl [10];
    tbl = '{"A", "C", "G", "T", "a", "c", "g", "t", "X", 8'h00};
    if ($urandom_range(0, 9) < 8) return tbl[$urandom_range(0, 3)];
    return tbl[$urandom_range(4, 9)];
  endfunction

  // monitor
  bit   pend;
  logic fv_prev;
  always @(negedge clk) begin
    if (reset) begin
      pend    = 1'b0;
      fv_prev = 1'b0;
    end else begin
      if (pend) begin
        if (bad_exp_q.size() == 0) check("bad_q_underflow", 1, 0);
        else check("bad_char", bp.bad_char, bad_exp_q.pop_front());
      end else begin
        check("bad_char_idle", bp.bad_char, 0);
      end
      pend = bp.base_valid & bp.base_ready;
      if (bp.frame_valid && !fv_prev) begin
        if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
        else begin
          frame_t f;
          f = exp_q.pop_front();
          check("reference", bp.reference, f.r);
          check("shortread", bp.shortread, f.s);
          check("err_count", bp.err_count, f.e);
        end
      end
      fv_prev = bp.frame_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] acgt [8];
    logic [2*NREF-1:0] ref_snap;
    logic [2*NREAD-1:0] read_snap;
    acgt = '{"A", "C", "G", "T", "A", "C", "G", "T"};
    reset = 1'b1;
    bp.base_char = 8'h00; bp.base_valid = 1'b0; bp.frame_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_reference", bp.reference, 0);
    check("rst_shortread", bp.shortread, 0);
    check("rst_frame_valid", bp.frame_valid, 0);
    check("rst_err", bp.err_count, 0);
    check("rst_ready", bp.base_ready, 0);
    reset = 1'b0;
    #1 check("ready_after_rst", bp.base_ready, 1);
    @(posedge clk); #1;

    // 50 x A + ACGTACGT
    for (int i = 0; i < NREF; i++) send("A");
    for (int i = 0; i < 7; i++) send(acgt[i]);
    check("fv_before_last", bp.frame_valid, 0);
    send(acgt[7]);
    check("fv_latency", bp.frame_valid, 1);
    check("t1_shortread", bp.shortread, 16'hD8D8);
    check("t1_reference", bp.reference, 0);
    // hold with valid asserted
    ref_snap = bp.reference; read_snap = bp.shortread;
    bp.base_char = "C";
    for (int i = 0; i < 10; i++) begin
      check("hold_ready", bp.base_ready, 0);
      check("hold_ref", bp.reference, ref_snap);
      check("hold_read", bp.shortread, read_snap);
      check("hold_fv", bp.frame_valid, 1);
      @(posedge clk); #1;
    end
    ack();

    // 50 x T + 8 x G
    for (int i = 0; i < NREF; i++) send("T");
    for (int i = 0; i < NREAD; i++) send("G");
    check("t2_reference", bp.reference, {2*NREF{1'b1}});
    check("t2_shortread", bp.shortread, 16'h5555);
    ack();

    // illegal byte after base 10
    for (int i = 0; i < 10; i++) send(acgt[$urandom_range(0, 3)]);
    send("X");
    for (int i = 0; i < 48; i++) send(acgt[$urandom_range(0, 3)]);
    check("t3_fv", bp.frame_valid, 1);
    check("t3_err", bp.err_count, 1);
    ack();

    // reset mid-frame
    for (int i = 0; i < 30; i++) send("G");
    bp.base_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_reference", bp.reference, 0);
    check("midrst_err", bp.err_count, 0);
    check("midrst_fv", bp.frame_valid, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NREF + NREAD - 1; i++) send(acgt[$urandom_range(0, 3)]);
    check("postrst_fv_57", bp.frame_valid, 0);
    send("T");
    check("postrst_fv_58", bp.frame_valid, 1);
    ack();

    // lowercase byte, then saturation
    send("a");
    idle(2);
`ifdef LOWERCASE_BASES_EN
    check("lower_a_err", bp.err_count, 0);
`else
    check("lower_a_err", bp.err_count, 1);
`endif
    for (int i = 0; i < 300; i++) send("X");
    idle(2);
    check("err_saturate", bp.err_count, 8'hFF);
    for (int i = 0; i < NREF + NREAD - 1 - ((code_of("a") >= 0) ? 1 : 0); i++)
      send(acgt[$urandom_range(0, 3)]);
    send("C");
    check("sat_frame_fv", bp.frame_valid, 1);
    ack();

    // randomized frames with gaps and ack delays
    for (int f = 0; f < 6; f++) begin
      int legal_n;
      legal_n = 0;
      while (legal_n < NREF + NREAD) begin
        logic [7:0] b;
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        b = rand_byte();
        if (code_of(b) >= 0) legal_n++;
        send(b);
      end
      bp.base_valid = 1'b0;
      check("rand_fv", bp.frame_valid, 1);
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      ack();
    end

    idle(3);
    check("frames_drained", exp_q.size(), 0);
    check("bad_drained", bad_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
